a_store: RTL and testbench
==========================

Name: a_store

Overview:
- Store path for the accumulator: moves a captured 16-bit word out to byte-wide data memory as two sequential byte writes, with a ready handshake and a timeout.
- It is the write-side counterpart of the accumulator's load-from-bus path.
- Sits between the datapath (accumulator output, address register) and the memory port.
- The control unit issues a one-cycle store pulse and waits for done or err.

Parameters:
- BIG_ENDIAN, 0: 0 writes the low byte at addr and the high byte at addr+1; 1 reverses the order.
- TIMEOUT, 255: maximum cycles to wait for mem_ready per byte (1..255).

Ports:
- clk  in  1  system clock; all state updates on the falling edge, matching the datapath registers
- rst_n  in  1  asynchronous, active-low reset
- store  in  1  start request, sampled only in IDLE
- a_in  in  16  word to store (accumulator value)
- addr_in  in  16  byte address of the first byte
- mem_addr  out  16  memory byte address
- mem_wdata  out  8  memory write data
- mem_we  out  1  write strobe, held until accepted
- mem_ready  in  1  memory accepts the current byte when high at a falling edge while mem_we=1
- busy  out  1  high from acceptance until return to IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, outputs mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, err=0; word/addr/counter registers = 0.
  - Takes effect immediately, including mid-transfer; a half-written word is not completed.
- States: IDLE, BYTE0, BYTE1, DONE, ERR.
- IDLE:
  - store=1 at a falling edge: capture a_in/addr_in, busy=1, go to BYTE0.
  - store=0: remain, all strobes 0.
- BYTE0:
  - mem_addr = captured addr.
  - mem_wdata = low byte if BIG_ENDIAN=0, else high byte.
  - mem_we = 1.
  - mem_ready=1 at an edge: go to BYTE1, counter cleared.
- BYTE1:
  - mem_addr = addr+1, 16-bit wrap (16'hFFFF+1 = 16'h0000).
  - mem_wdata = the other byte; mem_we = 1.
  - mem_ready=1: go to DONE.
- DONE: mem_we=0, done=1 for exactly one cycle, busy=1; next edge go to IDLE, busy=0.
- ERR: mem_we=0, err=1 for exactly one cycle; next edge go to IDLE, busy=0.
- Timeout:
  - 8-bit wait counter, cleared on entering each byte state, incremented every edge without ready.
  - If the counter equals TIMEOUT-1 and mem_ready=0: go to ERR.
  - mem_ready on that same edge wins (byte accepted).
- mem_ready is sampled only in BYTE0/BYTE1 and ignored elsewhere. Readiness already high on state entry is still sampled at the next edge, so each byte takes at least 1 cycle.
- Best case: store sampled at edge N; BYTE0 N..N+1, BYTE1 N+1..N+2, done high from N+2 to N+3, busy low after N+3.
- store while busy (including DONE/ERR): ignored, no queuing.
- a_in/addr_in changes after capture have no effect.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared CPU package: state encoding localparams (S_IDLE=0, S_BYTE0=1, S_BYTE1=2, S_DONE=3, S_ERR=4) and byte-order constants, alongside the existing accumulator op codes.
- Sub-module a_store_timer holds the wait counter: clear, enable, and expired output compared to TIMEOUT.
- FSM and datapath stay in a_store.

Test Plan:
- Basic write, BIG_ENDIAN=0, mem_ready tied 1: a_in=16'hBEEF, addr=16'h0100, store pulse -> (16'h0100, 8'hEF) then (16'h0101, 8'hBE) on consecutive cycles; done one cycle after; busy low one cycle later.
- BIG_ENDIAN=1, a_in=16'h1234, addr=16'h0200 -> 8'h12 at 16'h0200, 8'h34 at 16'h0201.
- Wrap-around: addr=16'hFFFF -> second byte at 16'h0000.
- Wait states: mem_ready low 3 cycles in BYTE0 and 2 in BYTE1 -> mem_we, mem_addr, mem_wdata stable throughout; done after both accepts; store pulses during busy ignored (exactly two writes total).
- Timeout, TIMEOUT=4, mem_ready held 0 -> err pulse one cycle after the 4th unanswered cycle, mem_we drops, no done; ready arriving on the final edge -> accepted, no err.
- Reset mid-transfer: rst_n low during BYTE1 -> mem_we, busy, done, err go 0 immediately; after release, a new store of 16'hA5A5 completes normally.

Source files
------------

// File: rtl/a_store_pkg.sv
// Shared CPU package: accumulator op codes, store-path state
// encoding and byte-order constants.
package a_store_pkg;

  typedef enum logic [1:0] {
    ACC_NOP,
    ACC_LOAD,
    ACC_STORE,
    ACC_CLR
  } acc_op_e;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BYTE0 = 3'd1;
  localparam logic [2:0] S_BYTE1 = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_BYTE0 = S_BYTE0,
    ST_BYTE1 = S_BYTE1,
    ST_DONE  = S_DONE,
    ST_ERR   = S_ERR
  } st_e;

  localparam bit ORDER_LE = 1'b0;
  localparam bit ORDER_BE = 1'b1;

  function automatic logic [7:0] pick_byte(
    input logic [15:0] w,
    input logic        hi
  );
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/a_store_timer.sv
// Per-byte wait counter for the accumulator store path;
// expired flags the last cycle allowed before abort.
module a_store_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/a_store.sv
// Accumulator store path: writes a captured 16-bit word as two
// byte writes with ready handshake and timeout abort.
module a_store
  import a_store_pkg::*;
#(
  parameter bit BIG_ENDIAN = ORDER_LE,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        store,
  input  logic [15:0] a_in,
  input  logic [15:0] addr_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  st_e         state, state_d;
  logic [15:0] word_q, word_d;
  logic [15:0] addr_q, addr_d;

  logic [15:0] mem_addr_d;
  logic [7:0]  mem_wdata_d;
  logic        mem_we_d;
  logic        busy_d;
  logic        done_d;
  logic        err_d;

  logic        t_clr;
  logic        t_en;
  logic        t_exp;

  a_store_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (t_clr),
    .en     (t_en),
    .expired(t_exp)
  );

  always_comb begin
    state_d = state;
    word_d  = word_q;
    addr_d  = addr_q;
    t_clr   = 1'b1;
    t_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (store) begin
          state_d = ST_BYTE0;
          word_d  = a_in;
          addr_d  = addr_in;
        end
      end
      ST_BYTE0,
      ST_BYTE1: begin
        t_clr = 1'b0;
        // an accept on the expiry edge still wins
        if (mem_ready) begin
          t_clr   = 1'b1;
          state_d = (state == ST_BYTE0) ? ST_BYTE1 : ST_DONE;
        end else if (t_exp) begin
          t_clr   = 1'b1;
          state_d = ST_ERR;
        end else begin
          t_en = 1'b1;
        end
      end
      ST_DONE,
      ST_ERR: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they leave a flop
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (1'b1)
      state_d == ST_BYTE0: begin
        mem_addr_d  = addr_d;
        mem_wdata_d = pick_byte(word_d, BIG_ENDIAN);
        mem_we_d    = 1'b1;
        busy_d      = 1'b1;
      end
      state_d == ST_BYTE1: begin
        mem_addr_d  = addr_d + 16'd1;
        mem_wdata_d = pick_byte(word_d, !BIG_ENDIAN);
        mem_we_d    = 1'b1;
        busy_d      = 1'b1;
      end
      state_d == ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      state_d == ST_ERR: begin
        busy_d = 1'b1;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      addr_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_a_store.sv
// Bench for a_store: little- and big-endian instances share stimulus
// and are checked against a byte-memory model and per-cycle rules.
module tb_a_store;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        store = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] addr_in = '0;

  logic [15:0] ma0, ma1;
  logic [7:0]  wd0, wd1;
  logic        we0, we1, busy0, busy1;
  logic        done0, done1, err0, err1;

  a_store #(.BIG_ENDIAN(1'b0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst_n(rst_n), .store(store),
    .a_in(a_in), .addr_in(addr_in),
    .mem_addr(ma0), .mem_wdata(wd0), .mem_we(we0),
    .mem_ready(mem_ready), .busy(busy0),
    .done(done0), .err(err0)
  );

  a_store #(.BIG_ENDIAN(1'b1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .store(store),
    .a_in(a_in), .addr_in(addr_in),
    .mem_addr(ma1), .mem_wdata(wd1), .mem_we(we1),
    .mem_ready(mem_ready), .busy(busy1),
    .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] mem0 [int];
  logic [7:0] mem1 [int];
  logic [7:0] ex0 [int];
  logic [7:0] ex1 [int];
  int wr0 = 0;
  int wr1 = 0;
  int ewr = 0;

  // memory side: a byte lands when ready meets a strobe at the edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (we0 && mem_ready) begin
        mem0[int'(ma0)] = wd0;
        wr0++;
      end
      if (we1 && mem_ready) begin
        mem1[int'(ma1)] = wd1;
        wr1++;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, ".we"}, {we0, we1}, 2'b00);
    chk({tag, ".busy"}, {busy0, busy1}, 2'b00);
    chk({tag, ".done"}, {done0, done1}, 2'b00);
    chk({tag, ".err"}, {err0, err1}, 2'b00);
  endtask

  task automatic chk_byte(string tag, int b, logic [15:0] ad,
                          logic [15:0] w);
    logic [7:0] lo, hi;
    lo = w[7:0];
    hi = w[15:8];
    chk({tag, ".we"}, {we0, we1}, 2'b11);
    chk({tag, ".busy"}, {busy0, busy1}, 2'b11);
    chk({tag, ".flags"}, {done0, done1, err0, err1}, 4'b0);
    chk({tag, ".addr0"}, ma0, ad);
    chk({tag, ".addr1"}, ma1, ad);
    chk({tag, ".data0"}, wd0, (b == 0) ? lo : hi);
    chk({tag, ".data1"}, wd1, (b == 0) ? hi : lo);
  endtask

  task automatic do_txn(logic [15:0] w, logic [15:0] ad,
                        int w0, int w1);
    logic [15:0] cur;
    logic [15:0] done_adr [$];
    int waits;
    bit to;
    to = 1'b0;
    store = 1'b1;
    a_in = w;
    addr_in = ad;
    mem_ready = 1'($urandom_range(0, 1));
    step();
    store = 1'b0;
    a_in = 16'($urandom);
    addr_in = 16'($urandom);
    for (int b = 0; b < 2; b++) begin
      waits = (b == 0) ? w0 : w1;
      cur = (b == 0) ? ad : ad + 16'd1;
      for (int k = 0; k < waits && k < TO; k++) begin
        chk_byte("wait", b, cur, w);
        mem_ready = 1'b0;
        store = 1'($urandom_range(0, 1));
        step();
      end
      if (waits >= TO) begin
        to = 1'b1;
        break;
      end
      chk_byte("byte", b, cur, w);
      mem_ready = 1'b1;
      store = 1'($urandom_range(0, 1));
      step();
      ex0[int'(cur)] = (b == 0) ? w[7:0] : w[15:8];
      ex1[int'(cur)] = (b == 0) ? w[15:8] : w[7:0];
      done_adr.push_back(cur);
      ewr++;
    end
    mem_ready = 1'($urandom_range(0, 1));
    chk("end.we", {we0, we1}, 2'b00);
    chk("end.busy", {busy0, busy1}, 2'b11);
    chk("end.done", {done0, done1}, to ? 2'b00 : 2'b11);
    chk("end.err", {err0, err1}, to ? 2'b11 : 2'b00);
    store = 1'($urandom_range(0, 1));
    step();
    store = 1'b0;
    chk_quiet("idle");
    chk("wr0", wr0, ewr);
    chk("wr1", wr1, ewr);
    foreach (done_adr[i]) begin
      chk("mem0", mem0[int'(done_adr[i])], ex0[int'(done_adr[i])]);
      chk("mem1", mem1[int'(done_adr[i])], ex1[int'(done_adr[i])]);
    end
  endtask

  initial begin
    #1;
    chk_quiet("rst");
    chk("rst.addr", {ma0, ma1}, 32'h0);
    chk("rst.data", {wd0, wd1}, 16'h0);
    @(posedge clk);
    rst_n = 1'b1;
    step();
    chk_quiet("post_rst");

    do_txn(16'hBEEF, 16'h0100, 0, 0);
    do_txn(16'h1234, 16'h0200, 0, 0);
    do_txn(16'hC3A7, 16'hFFFF, 0, 0);
    do_txn(16'h9E61, 16'h0450, 3, 2);
    do_txn(16'h7007, 16'h0500, 4, 0);
    do_txn(16'h0BAD, 16'h0600, 0, 4);
    do_txn(16'h6116, 16'h0700, 3, 3);

    // reset while the second byte is pending
    store = 1'b1;
    a_in = 16'h5A5A;
    addr_in = 16'h3000;
    step();
    store = 1'b0;
    mem_ready = 1'b1;
    step();
    ex0[32'h3000] = 8'h5A;
    ex1[32'h3000] = 8'h5A;
    ewr++;
    mem_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("arst");
    step();
    rst_n = 1'b1;
    step();
    chk_quiet("arst.rel");
    chk("arst.nobyte1", mem0.exists(32'h3001), 0);
    do_txn(16'hA5A5, 16'h4000, 0, 0);

    repeat (40) begin
      do_txn(16'($urandom), 16'($urandom),
             $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
